// File: rtl/fetch_pc_unit.sv
// Fetch / next-PC engine for a multi-cycle RV32IM core.
// It fetches one instruction at a time from a variable-latency memory.
// It holds that instruction until the execute stage retires it.
// On retire it resolves the next PC from trap, mret, jump and branch inputs, and counts retired instructions.
module fetch_pc_unit #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
    parameter bit              CHECK_MISALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            trap_enter,
    input  logic            trap_exit,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            jump,
    input  logic            jump_r,
    input  logic            branch,
    input  logic [2:0]      branch_type,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr,
    output logic [63:0]     instret
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [XLEN-1:0] CLEAR_BIT0  = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] CLEAR_BITS1 = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic            accept;
    logic            retire;
    logic            branch_taken;
    logic [XLEN-1:0] jr_target;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] target_fixed;
    logic            redirect;
    logic            target_misaligned;
    logic            raise_misalign;
    logic [XLEN-1:0] next_pc;

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign accept      = (state == FETCH) && imem_ack;
    assign retire      = (state == HOLD) && instr_ready;

    assign jr_target  = (rs1_val + imm) & CLEAR_BIT0;
    assign rel_target = instr_pc + imm;
    assign seq_pc     = instr_pc + XLEN'(4);

    // FSM state register; reset abandons any in-flight fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state: one IDLE cycle, then alternate FETCH / HOLD
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem_ack) state_next = HOLD;
            HOLD:    if (instr_ready) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Branch condition from funct3; BLT/BGE signed, BLTU/BGEU unsigned
    always_comb begin
        branch_taken = 1'b0;
        case (branch_type)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    // Pick the control-transfer target (JALR over JAL over taken branch)
    always_comb begin
        target   = rel_target;
        redirect = 1'b0;
        if (jump_r) begin
            target   = jr_target;
            redirect = 1'b1;
        end else if (jump || (branch && branch_taken)) begin
            redirect = 1'b1;
        end
    end

    generate
        if (CHECK_MISALIGN) begin : g_check
            assign target_misaligned = redirect && (target[1:0] != 2'b00);
            assign target_fixed      = target;
        end else begin : g_force
            assign target_misaligned = 1'b0;
            assign target_fixed      = target & CLEAR_BITS1;
        end
    endgenerate

    // Traps are never alignment-checked, so a trap or mret masks the exception
    assign raise_misalign = !trap_enter && !trap_exit && target_misaligned;

    // Next PC by priority: trap, mret, redirect (or misalign vector), sequential
    always_comb begin
        next_pc = seq_pc;
        if (trap_enter)         next_pc = mtvec;
        else if (trap_exit)     next_pc = mepc;
        else if (raise_misalign) next_pc = mtvec;
        else if (redirect)      next_pc = target_fixed;
    end

    // PC and held instruction; the held copy only changes when a fetch is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            if (accept) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (retire) pc <= next_pc;
        end
    end

    // Retire bookkeeping: instret count and one-cycle misalign pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret       <= '0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_exc <= 1'b0;
            if (retire) begin
                instret <= instret + 64'd1;
                if (raise_misalign) begin
                    misalign_exc  <= 1'b1;
                    misalign_addr <= target;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit.
// Expected fetch addresses are queued when a retire is driven and popped when the DUT requests the next fetch.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        trap_enter, trap_exit;
    logic [31:0] mtvec, mepc;
    logic        jump, jump_r, branch;
    logic [2:0]  branch_type;
    logic [31:0] imm, rs1_val, rs2_val;
    logic        misalign_exc;
    logic [31:0] misalign_addr;
    logic [63:0] instret;

    fetch_pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h100), .CHECK_MISALIGN(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .trap_enter(trap_enter), .trap_exit(trap_exit),
        .mtvec(mtvec), .mepc(mepc),
        .jump(jump), .jump_r(jump_r), .branch(branch), .branch_type(branch_type),
        .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
        .instret(instret)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_data;
    logic [63:0] exp_instret = 64'd0;
    logic [31:0] exp_maddr   = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic redir(input logic te, input logic tx, input logic jr, input logic j,
                         input logic br, input logic [2:0] bt, input logic [31:0] im,
                         input logic [31:0] r1, input logic [31:0] r2);
        trap_enter = te; trap_exit = tx; jump_r = jr; jump = j; branch = br;
        branch_type = bt; imm = im; rs1_val = r1; rs2_val = r2;
    endtask

    // Wait for a request, compare its address to the queue, ack after ack_delay cycles
    task automatic fetch(input int ack_delay);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req_seen", imem_req, 1'b1);
        if (exp_q.size() == 0) begin
            check("fetch_queue_nonempty", 1'b0, 1'b1);
            cur_pc = 32'hDEAD_BEEF;
        end else begin
            cur_pc = exp_q.pop_front();
        end
        check("fetch_addr", imem_addr, cur_pc);
        cur_data = cur_pc ^ 32'h5A5A_0013;
        repeat (ack_delay) begin
            @(negedge clk);
            check("req_stable", imem_req, 1'b1);
            check("addr_stable", imem_addr, cur_pc);
            check("no_valid_while_fetching", instr_valid, 1'b0);
        end
        imem_ack   = 1'b1;
        imem_rdata = cur_data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("misalign_pulse_cleared", misalign_exc, 1'b0);
    endtask

    // Check the held instruction, retire it after rdy_delay cycles, queue the expected next fetch
    task automatic retire(input int rdy_delay, input logic [31:0] exp_next,
                          input logic exp_exc, input logic [31:0] maddr);
        check("hold_valid", instr_valid, 1'b1);
        check("hold_instr", instr, cur_data);
        check("hold_instr_pc", instr_pc, cur_pc);
        check("hold_no_req", imem_req, 1'b0);
        repeat (rdy_delay) begin
            @(negedge clk);
            check("hold_valid_stable", instr_valid, 1'b1);
            check("hold_instr_stable", instr, cur_data);
            check("hold_pc_stable", instr_pc, cur_pc);
            check("hold_instret_stable", instret, exp_instret);
        end
        instr_ready = 1'b1;
        exp_q.push_back(exp_next);
        exp_instret++;
        if (exp_exc) exp_maddr = maddr;
        @(negedge clk);
        instr_ready = 1'b0;
        redir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, $urandom, $urandom, $urandom);
        check("instret", instret, exp_instret);
        check("misalign_exc", misalign_exc, exp_exc);
        check("misalign_addr", misalign_addr, exp_maddr);
        check("valid_dropped", instr_valid, 1'b0);
        $display("retire pc=%h instr=%h next=%h exc=%0d instret=%0d",
                 cur_pc, cur_data, exp_next, exp_exc, exp_instret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        mtvec = 32'h80; mepc = 32'h500;
        redir(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_exc", misalign_exc, 1'b0);
        check("rst_maddr", misalign_addr, 32'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_pc", imem_addr, 32'h100);
        rst = 1'b0;
        check("idle_req", imem_req, 1'b0);
        @(negedge clk);
        exp_q.push_back(32'h100);

        // Sequential fetches with immediate ack and ready
        fetch(0); retire(0, 32'h104, 1'b0, 32'd0);
        fetch(0); retire(0, 32'h108, 1'b0, 32'd0);
        fetch(0); retire(0, 32'h10C, 1'b0, 32'd0);
        check("instret_after_three", instret, 64'd3);

        // Slow memory, then ready withheld
        fetch(3); retire(2, 32'h110, 1'b0, 32'd0);

        // JAL to 0x200
        fetch(0); redir(0, 0, 0, 1, 0, 3'b000, 32'hF0, 32'd0, 32'd0);
        retire(0, 32'h200, 1'b0, 32'd0);
        // BLT: -1 < 1 signed, taken to 0x210
        fetch(0); redir(0, 0, 0, 0, 1, 3'b100, 32'd16, 32'hFFFF_FFFF, 32'd1);
        retire(0, 32'h210, 1'b0, 32'd0);
        // JAL back by -16
        fetch(0); redir(0, 0, 0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'd0);
        retire(0, 32'h200, 1'b0, 32'd0);
        // BLTU: 0xFFFFFFFF < 1 unsigned is false, falls through
        fetch(0); redir(0, 0, 0, 0, 1, 3'b110, 32'd16, 32'hFFFF_FFFF, 32'd1);
        retire(0, 32'h204, 1'b0, 32'd0);
        // BGEU taken
        fetch(0); redir(0, 0, 0, 0, 1, 3'b111, 32'd8, 32'hFFFF_FFFF, 32'd1);
        retire(0, 32'h20C, 1'b0, 32'd0);
        // JALR clears bit 0, no exception
        fetch(0); redir(0, 0, 1, 0, 0, 3'b000, 32'd0, 32'h301, 32'd0);
        retire(0, 32'h300, 1'b0, 32'd0);
        fetch(0); redir(0, 0, 0, 1, 0, 3'b000, 32'h100, 32'd0, 32'd0);
        retire(0, 32'h400, 1'b0, 32'd0);
        // Misaligned JAL target goes to mtvec with a pulse
        fetch(0); redir(0, 0, 0, 1, 0, 3'b000, 32'd6, 32'd0, 32'd0);
        retire(0, 32'h80, 1'b1, 32'h406);
        // trap_enter beats trap_exit and jump
        fetch(0); redir(1, 1, 0, 1, 0, 3'b000, 32'h10, 32'd0, 32'd0);
        retire(0, 32'h80, 1'b0, 32'd0);
        // mret alone
        fetch(0); redir(0, 1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'd0);
        retire(0, 32'h500, 1'b0, 32'd0);
        // Not-taken BEQ with misaligned offset raises nothing
        fetch(0); redir(0, 0, 0, 0, 1, 3'b000, 32'd3, 32'd1, 32'd2);
        retire(0, 32'h504, 1'b0, 32'd0);
        // BGE signed: -1 >= 1 false
        fetch(0); redir(0, 0, 0, 0, 1, 3'b101, 32'h0C, 32'hFFFF_FFFF, 32'd1);
        retire(0, 32'h508, 1'b0, 32'd0);
        // JALR to the top word, then sequential wrap to 0
        fetch(0); redir(0, 0, 1, 0, 0, 3'b000, 32'h0C, 32'hFFFF_FFF0, 32'd0);
        retire(0, 32'hFFFF_FFFC, 1'b0, 32'd0);
        fetch(0); retire(0, 32'h0, 1'b0, 32'd0);

        // Reset in the middle of a fetch wait with an ack about to arrive
        begin
            int n = 0;
            while (!imem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("wrap_req_seen", imem_req, 1'b1);
            cur_pc = exp_q.pop_front();
            check("wrap_fetch_addr", imem_addr, cur_pc);
        end
        repeat (2) @(negedge clk);
        #2;
        rst      = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        check("async_rst_req", imem_req, 1'b0);
        check("async_rst_instret", instret, 64'd0);
        check("async_rst_maddr", misalign_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 64'd0;
        exp_maddr   = 32'd0;
        exp_q.delete();
        check("post_rst_idle_req", imem_req, 1'b0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("post_rst_fetch_req", imem_req, 1'b1);
        check("post_rst_no_stray_valid", instr_valid, 1'b0);
        check("post_rst_instr", instr, 32'd0);
        exp_q.push_back(32'h100);
        fetch(1); retire(0, 32'h104, 1'b0, 32'd0);
        fetch(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
